// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with a local word-addressed data memory of fixed
// access latency; ALU results pass straight through, valid/ready on both sides.
module mem_access_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_store_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_wen,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, WAIT, FULL} state_t;
    state_t state, state_nxt;
    logic [3:0]        cnt;
    logic              load_q;
    logic [4:0]        rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] sdata_q;
    logic [DATA_W-1:0] mem [0:2**ADDR_W-1];
    logic              accept, is_mem, commit;
    // Byte-offset bits and address bits above the memory depth are deliberately dropped.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{in_result[1:0], in_result[DATA_W-1:ADDR_W+2]};
    assign in_ready  = rst_n & (state == IDLE | (state == FULL & out_ready));
    assign accept    = in_valid & in_ready;
    assign is_mem    = in_op == 2'b01 || in_op == 2'b10;
    assign commit    = state == WAIT && cnt == 4'd1;
    assign out_valid = state == FULL;
    assign busy      = state == WAIT;
    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = is_mem ? WAIT : FULL;
        else if (commit)
            state_nxt = FULL;
        else if (state == FULL && out_ready)
            state_nxt = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            load_q   <= 1'b0;
            rd_q     <= '0;
            addr_q   <= '0;
            sdata_q  <= '0;
            out_rd   <= '0;
            out_data <= '0;
            out_wen  <= 1'b0;
        end else if (accept) begin
            cnt     <= 4'(MEM_LAT);
            load_q  <= in_op == 2'b01;
            rd_q    <= in_rd;
            addr_q  <= in_result[ADDR_W+1:2];
            sdata_q <= in_store_data;
            if (!is_mem) begin
                out_rd   <= in_rd;
                out_data <= in_result;
                out_wen  <= in_rd != 5'd0;
            end
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                out_rd   <= rd_q;
                out_data <= load_q ? mem[addr_q] : '0;
                out_wen  <= load_q && rd_q != 5'd0;
            end
        end
    end
    // Reset gates the commit so a store caught mid-flight is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && commit && !load_q)
            mem[addr_q] <= sdata_q;
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed checks of pass-through, memory latency, backpressure,
// address wrap and reset during an in-flight store.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_wen, busy;
    logic [1:0]  in_op;
    logic [4:0]  in_rd, out_rd;
    logic [31:0] in_result, in_store_data, out_data;
    int checks = 0;
    int errs = 0;

    mem_access_stage #(.DATA_W(32), .ADDR_W(8), .MEM_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_result(in_result), .in_store_data(in_store_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_data(out_data), .out_wen(out_wen), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [4:0] rd,
                         input logic [31:0] res, input logic [31:0] sd);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_result = res; in_store_data = sd;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 2'b00; in_rd = 5'd0; in_result = '0; in_store_data = '0;
        tick; tick;
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (out_data !== 32'h0) begin errs++; $display("FAIL rst_out_data got %h exp 0", out_data); end
        checks++; if (out_wen !== 1'b0 || out_rd !== 5'd0 || busy !== 1'b0) begin errs++; $display("FAIL rst_misc got wen=%b rd=%0d busy=%b exp 0/0/0", out_wen, out_rd, busy); end
        rst_n = 1'b1;
        tick;
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_release_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_pass;
        logic [31:0] vals [4];
        logic [4:0]  rds  [4];
        vals = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
        rds  = '{5'd1, 5'd0, 5'd31, 5'd12};
        out_ready = 1'b1;
        drive(2'b00, 5'd5, 32'h0000_1234, 32'h0);
        tick;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL pass_valid got %b exp 1", out_valid); end
        checks++; if (out_rd !== 5'd5 || out_data !== 32'h1234 || out_wen !== 1'b1) begin errs++; $display("FAIL pass_out got rd=%0d data=%h wen=%b exp 5/00001234/1", out_rd, out_data, out_wen); end
        for (int i = 0; i < 4; i++) begin
            drive(i == 3 ? 2'b11 : 2'b00, rds[i], vals[i], 32'hFFFF_FFFF);
            tick;
            checks++;
            if (out_valid !== 1'b1 || out_rd !== rds[i] || out_data !== vals[i] || out_wen !== (rds[i] != 5'd0)) begin
                errs++;
                $display("FAIL stream_%0d got v=%b rd=%0d data=%h wen=%b exp 1/%0d/%h/%b", i, out_valid, out_rd, out_data, out_wen, rds[i], vals[i], rds[i] != 5'd0);
            end
        end
        in_valid = 1'b0;
        tick;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h4444_0004) begin errs++; $display("FAIL pass_drain got v=%b data=%h exp 0/44440004", out_valid, out_data); end
    endtask

    task automatic test_store_load;
        out_ready = 1'b1;
        drive(2'b10, 5'd3, 32'h0000_0010, 32'hDEAD_BEEF);
        for (int c = 1; c <= 3; c++) begin
            tick;
            in_valid = 1'b0;
            if (c < 3) begin
                checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin errs++; $display("FAIL st_wait_%0d got busy=%b rdy=%b v=%b exp 1/0/0", c, busy, in_ready, out_valid); end
            end
        end
        checks++; if (out_valid !== 1'b1 || out_wen !== 1'b0 || out_data !== 32'h0 || out_rd !== 5'd3) begin errs++; $display("FAIL st_done got v=%b wen=%b data=%h rd=%0d exp 1/0/0/3", out_valid, out_wen, out_data, out_rd); end
        drive(2'b01, 5'd7, 32'h0000_0010, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            tick;
            in_valid = 1'b0;
            if (c < 3) begin
                checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin errs++; $display("FAIL ld_wait_%0d got busy=%b rdy=%b v=%b exp 1/0/0", c, busy, in_ready, out_valid); end
            end
        end
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_wen !== 1'b1 || out_rd !== 5'd7) begin errs++; $display("FAIL ld_done got v=%b data=%h wen=%b rd=%0d exp 1/deadbeef/1/7", out_valid, out_data, out_wen, out_rd); end
        tick;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'hDEAD_BEEF || busy !== 1'b0) begin errs++; $display("FAIL ld_idle got v=%b data=%h busy=%b exp 0/deadbeef/0", out_valid, out_data, busy); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(2'b00, 5'd9, 32'h0000_CAFE, 32'h0);
        tick;
        drive(2'b00, 5'd10, 32'h0000_BEEF, 32'h0);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'hCAFE || out_rd !== 5'd9 || out_wen !== 1'b1 || in_ready !== 1'b0) begin
                errs++;
                $display("FAIL bp_hold_%0d got v=%b data=%h rd=%0d wen=%b rdy=%b exp 1/0000cafe/9/1/0", c, out_valid, out_data, out_rd, out_wen, in_ready);
            end
            in_result = 32'h0000_BEEF + 32'(c);
            tick;
        end
        in_result = 32'h0000_BEEF;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
        tick;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hBEEF || out_rd !== 5'd10) begin errs++; $display("FAIL bp_next got v=%b data=%h rd=%0d exp 1/0000beef/10", out_valid, out_data, out_rd); end
        tick;
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_no_dup got v=%b exp 0", out_valid); end
    endtask

    task automatic test_wrap_rd0;
        out_ready = 1'b1;
        drive(2'b10, 5'd2, 32'h0000_0403, 32'h0000_0055);
        tick; in_valid = 1'b0; tick; tick;
        checks++; if (out_valid !== 1'b1 || out_wen !== 1'b0) begin errs++; $display("FAIL wrap_st got v=%b wen=%b exp 1/0", out_valid, out_wen); end
        drive(2'b01, 5'd0, 32'h0000_0000, 32'h0);
        tick; in_valid = 1'b0; tick; tick;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h55 || out_wen !== 1'b0 || out_rd !== 5'd0) begin errs++; $display("FAIL wrap_ld got v=%b data=%h wen=%b rd=%0d exp 1/00000055/0/0", out_valid, out_data, out_wen, out_rd); end
        tick;
    endtask

    task automatic test_reset_mid_wait;
        out_ready = 1'b1;
        drive(2'b10, 5'd1, 32'h0000_0020, 32'h0000_1111);
        tick; in_valid = 1'b0; tick; tick; tick;
        drive(2'b10, 5'd1, 32'h0000_0020, 32'h0000_AAAA);
        tick; in_valid = 1'b0; tick;
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL rw_last_wait got busy=%b exp 1", busy); end
        rst_n = 1'b0;
        tick;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0) begin errs++; $display("FAIL rw_reset got v=%b busy=%b rdy=%b data=%h exp 0/0/0/0", out_valid, busy, in_ready, out_data); end
        rst_n = 1'b1;
        tick;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL rw_after got v=%b rdy=%b exp 0/1", out_valid, in_ready); end
        drive(2'b01, 5'd4, 32'h0000_0020, 32'h0);
        tick; in_valid = 1'b0; tick; tick;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h1111 || out_rd !== 5'd4) begin errs++; $display("FAIL rw_load got v=%b data=%h rd=%0d exp 1/00001111/4", out_valid, out_data, out_rd); end
        tick;
    endtask

    initial begin
        test_reset;
        test_pass;
        test_store_load;
        test_backpressure;
        test_wrap_rd0;
        test_reset_mid_wait;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end
endmodule
